// File: rtl/fir_mac_engine.sv
// ---------------------------------------------------------------------------------------------
// fir_mac_engine
//
// Time-multiplexed FIR multiply-accumulate stage. On a sample strobe the parallel taps from the
// upstream shift register are snapshotted. The stage then accumulates tap[i]*coef[i] serially,
// one tap per clock. The sum is rounded (half toward +inf), arithmetically shifted by OUT_SHIFT
// and saturated to a DATA_WIDTH result. A programmable coefficient bank is written through a
// simple address/data port while the engine is idle.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset (clears coefficients too)
//   start      sample strobe; taps are valid in this cycle
//   taps       NUM_REGS x DATA_WIDTH parallel taps, index 0 = newest
//   coef_we    coefficient write enable (honoured only when idle and not starting)
//   coef_addr  coefficient index
//   coef_data  signed coefficient value
//   y          signed filter output, held until the next result
//   y_valid    one-cycle pulse when y updates
//   busy       high while a computation is in progress
//   overrun    sticky flag, set when a start arrives while busy (cleared by rst only)
// ---------------------------------------------------------------------------------------------
module fir_mac_engine #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned OUT_SHIFT  = 0,
    localparam int unsigned IdxW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  taps,
    input  logic                                 coef_we,
    input  logic [IdxW-1:0]                      coef_addr,
    input  logic signed [COEF_WIDTH-1:0]         coef_data,
    output logic signed [DATA_WIDTH-1:0]         y,
    output logic                                 y_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int unsigned ProdW = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned RndW  = ACC_WIDTH + 1;
    localparam int unsigned RndPos = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

    // Rounding is done one bit wider than the accumulator so the bias can never wrap.
    localparam logic signed [RndW-1:0] RndOne   = RndW'(1);
    localparam logic signed [RndW-1:0] RndConst = (OUT_SHIFT > 0) ? (RndOne <<< RndPos) : '0;
    localparam logic signed [RndW-1:0] YMax =
        {{(RndW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [RndW-1:0] YMin =
        {{(RndW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } state_e;

    state_e                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   snap_q [NUM_REGS];
    logic signed [DATA_WIDTH-1:0]   snap_d [NUM_REGS];
    logic signed [COEF_WIDTH-1:0]   coef_q [NUM_REGS];
    logic signed [COEF_WIDTH-1:0]   coef_d [NUM_REGS];
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [IdxW-1:0]                idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]   y_q, y_d;
    logic                           y_valid_q, y_valid_d;
    logic                           overrun_q, overrun_d;

    // Datapath: one full-precision product per MAC cycle, sign-extended into the accumulator.
    logic signed [DATA_WIDTH-1:0]   snap_sel;
    logic signed [COEF_WIDTH-1:0]   coef_sel;
    logic signed [ProdW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [RndW-1:0]         rnd;
    logic signed [RndW-1:0]         shifted;
    logic signed [DATA_WIDTH-1:0]   y_sat;
    logic                           addr_ok;

    always_comb begin
        snap_sel = snap_q[idx_q];
        coef_sel = coef_q[idx_q];
        prod     = snap_sel * coef_sel;
        prod_ext = {{(ACC_WIDTH - ProdW){prod[ProdW-1]}}, prod};
    end

    always_comb begin
        rnd     = {acc_q[ACC_WIDTH-1], acc_q} + RndConst;
        shifted = rnd >>> OUT_SHIFT;
        if (shifted > YMax) begin
            y_sat = YMax[DATA_WIDTH-1:0];
        end else if (shifted < YMin) begin
            y_sat = YMin[DATA_WIDTH-1:0];
        end else begin
            y_sat = shifted[DATA_WIDTH-1:0];
        end
    end

    // Needed only when NUM_REGS is not a power of two.
    assign addr_ok = (32'(coef_addr) < NUM_REGS);

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        coef_d    = coef_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A write coinciding with an accepted start is dropped.
                    for (int i = 0; i < int'(NUM_REGS); i++) begin
                        snap_d[i] = taps[i];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StMac;
                end else if (coef_we && addr_ok) begin
                    coef_d[coef_addr] = coef_data;
                end
            end
            StMac: begin
                acc_d = acc_q + prod_ext;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StOut;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
                if (start) begin
                    overrun_d = 1'b1;
                end
            end
            StOut: begin
                y_d       = y_sat;
                y_valid_d = 1'b1;
                state_d   = StIdle;
                if (start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            idx_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                snap_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                snap_q[i] <= snap_d[i];
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != StIdle);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// ---------------------------------------------------------------------------------------------
// tb_fir_mac_engine
//
// Two engines (NUM_REGS=4) share all inputs: dut0 uses OUT_SHIFT=0, dut2 uses OUT_SHIFT=2.
// Table-driven vectors of {coefs, taps, expected y for each engine}, followed by hand-written
// sequences for overrun, dropped coefficient writes and reset during a computation.
// ---------------------------------------------------------------------------------------------
module tb_fir_mac_engine;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [3:0][15:0]          taps;
    logic                      coef_we;
    logic [1:0]                coef_addr;
    logic signed [15:0]        coef_data;

    logic signed [15:0]        y0, y2;
    logic                      y_valid0, y_valid2;
    logic                      busy0, busy2;
    logic                      overrun0, overrun2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_mac_engine #(
        .DATA_WIDTH (16),
        .NUM_REGS   (4),
        .COEF_WIDTH (16),
        .ACC_WIDTH  (40),
        .OUT_SHIFT  (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .taps      (taps),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .y         (y0),
        .y_valid   (y_valid0),
        .busy      (busy0),
        .overrun   (overrun0)
    );

    fir_mac_engine #(
        .DATA_WIDTH (16),
        .NUM_REGS   (4),
        .COEF_WIDTH (16),
        .ACC_WIDTH  (40),
        .OUT_SHIFT  (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .taps      (taps),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .y         (y2),
        .y_valid   (y_valid2),
        .busy      (busy2),
        .overrun   (overrun2)
    );

    typedef struct packed {
        logic [3:0][15:0]   coef;
        logic [3:0][15:0]   tap;
        logic signed [15:0] y0;
        logic signed [15:0] y2;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [3:0][15:0] pack4(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] r;
        r[0] = a[15:0];
        r[1] = b[15:0];
        r[2] = c[15:0];
        r[3] = d[15:0];
        return r;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_coefs(input logic [3:0][15:0] c);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = 2'(i);
            coef_data = c[i];
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic do_start(input logic [3:0][15:0] t);
        @(negedge clk);
        start = 1'b1;
        taps  = t;
    endtask

    // Waits for the result; 'already' negedges after the start cycle have been consumed.
    task automatic wait_result(input int already, input logic signed [15:0] e0,
                               input logic signed [15:0] e2, input string nm);
        int lat = 0;
        int bc  = 0;
        bit got = 1'b0;
        logic signed [15:0] held;
        for (int k = already + 1; k <= already + 20 && !got; k++) begin
            @(negedge clk);
            start   = 1'b0;
            coef_we = 1'b0;
            if (busy0) bc++;
            if (y_valid0) begin
                got = 1'b1;
                lat = k;
                check({nm, " y0"}, y0, e0);
                check({nm, " y2"}, y2, e2);
                check({nm, " y_valid2"}, 32'(y_valid2), 1);
            end
        end
        check({nm, " latency"}, lat, 6);
        check({nm, " busy cycles"}, bc, 5 - already);
        held = y0;
        @(negedge clk);
        check({nm, " y_valid drop"}, 32'(y_valid0), 0);
        check({nm, " y held"}, y0, held);
    endtask

    initial begin
        int vcount;
        rst       = 1'b1;
        start     = 1'b0;
        taps      = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        // Vector table: coef/tap index 0 first; y0 at OUT_SHIFT=0, y2 at OUT_SHIFT=2.
        vecs[0] = {pack4(0, 0, 0, 0),                 pack4(1, 2, 3, 4),
                   16'sd0, 16'sd0};
        vecs[1] = {pack4(1, 1, 1, 1),                 pack4(1, 2, 3, 4),
                   16'sd10, 16'sd3};
        vecs[2] = {pack4(-2, 3, 0, 1),                pack4(5, -4, 7, -1),
                   -16'sd23, -16'sd6};
        vecs[3] = {pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767),
                   16'sd32767, 16'sd32767};
        vecs[4] = {pack4(32767, 32767, 32767, 32767), pack4(-32768, -32768, -32768, -32768),
                   -16'sd32768, -16'sd32768};
        vecs[5] = {pack4(1, 0, 0, 0),                 pack4(10, 99, -99, 7),
                   16'sd10, 16'sd3};
        vecs[6] = {pack4(1, 0, 0, 0),                 pack4(-10, 5, 5, 5),
                   -16'sd10, -16'sd2};
        vecs[7] = {pack4(1, 0, 0, 0),                 pack4(6, 0, 0, 0),
                   16'sd6, 16'sd2};
        vecs[8] = {pack4(1, 1, 0, 0),                 pack4(32767, 1, 0, 0),
                   16'sd32767, 16'sd8192};
        vecs[9] = {pack4(1, 0, 0, 0),                 pack4(-32768, 3, 3, 3),
                   -16'sd32768, -16'sd8192};
        vcount = 10;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset y", y0, 0);
        check("reset y_valid", 32'(y_valid0), 0);
        check("reset busy", 32'(busy0), 0);
        check("reset overrun", 32'(overrun0), 0);

        for (int i = 0; i < vcount; i++) begin
            write_coefs(vecs[i].coef);
            do_start(vecs[i].tap);
            wait_result(0, vecs[i].y0, vecs[i].y2, $sformatf("vec%0d", i));
        end
        check("overrun after vectors", 32'(overrun0), 0);

        // Restart in the very cycle y_valid is high.
        write_coefs(pack4(1, 1, 1, 1));
        do_start(pack4(1, 2, 3, 4));
        begin
            bit seen = 1'b0;
            for (int k = 1; k <= 20 && !seen; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (y_valid0) seen = 1'b1;
            end
            check("b2b first valid", 32'(seen), 1);
            start = 1'b1;
            taps  = pack4(2, 2, 2, 2);
        end
        wait_result(0, 16'sd8, 16'sd2, "b2b second");
        check("b2b overrun", 32'(overrun0), 0);

        // Second start two cycles after an accepted one, plus a coef write while busy.
        do_start(pack4(1, 2, 3, 4));
        @(negedge clk);
        start     = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 16'sd50;
        @(negedge clk);
        coef_we = 1'b0;
        start   = 1'b1;
        taps    = pack4(100, 100, 100, 100);
        @(negedge clk);
        start = 1'b0;
        wait_result(3, 16'sd10, 16'sd3, "overrun run");
        check("overrun set", 32'(overrun0), 1);

        // Coef write in the same cycle as an accepted start must be dropped.
        do_start(pack4(1, 2, 3, 4));
        coef_we   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 16'sd7;
        wait_result(0, 16'sd10, 16'sd3, "busy write dropped");
        check("overrun sticky", 32'(overrun0), 1);

        // Reset during the second MAC cycle aborts the computation.
        do_start(pack4(1, 2, 3, 4));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            int vseen = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (y_valid0) vseen++;
            end
            check("abort no y_valid", vseen, 0);
        end
        check("abort y", y0, 0);
        check("abort busy", 32'(busy0), 0);
        check("abort overrun", 32'(overrun0), 0);
        do_start(pack4(1, 2, 3, 4));
        wait_result(0, 16'sd0, 16'sd0, "coefs cleared");
        write_coefs(pack4(1, 1, 1, 1));
        do_start(pack4(1, 2, 3, 4));
        wait_result(0, 16'sd10, 16'sd3, "after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Time-multiplexed FIR multiply-accumulate stage.
- Sits directly downstream of the tap shift register and consumes its parallel tap outputs.
- On each sample strobe, snapshots all taps and accumulates tap[i]*coef[i] serially, one tap per clock.
- Rounds, shifts and saturates the sum to a DATA_WIDTH result. Holds a programmable coefficient bank.

Parameters:
- DATA_WIDTH, 16, signed width of taps and result y.
- NUM_REGS, 8, number of taps/coefficients (>=2).
- COEF_WIDTH, 16, signed coefficient width.
- ACC_WIDTH, 40, signed accumulator width; must be >= DATA_WIDTH+COEF_WIDTH+clog2(NUM_REGS), so the accumulator never wraps.
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..ACC_WIDTH-DATA_WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  sample strobe; new taps valid this cycle.
- taps  in  DATA_WIDTH x NUM_REGS  signed parallel taps, index 0 = newest.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  clog2(NUM_REGS)  coefficient index.
- coef_data  in  COEF_WIDTH  signed coefficient value.
- y  out  DATA_WIDTH  signed filter output, held until next result.
- y_valid  out  1  one-cycle pulse when y updates.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky; set when start is dropped.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; y=0, y_valid=0, busy=0, overrun=0.
  - All coefficients=0; accumulator and index=0.
  - rst has priority over every other input.
  - rst asserted mid-operation aborts the computation: no y_valid, coefficients cleared.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - start=1 at an edge: copy taps into an internal snapshot, acc=0, idx=0, go to MAC.
  - The upstream register may shift freely after this edge.
- MAC:
  - Each edge: acc <= acc + sext(snap[idx]) * sext(coef[idx]) (full-precision signed product); idx++.
  - After the edge processing idx==NUM_REGS-1, go to OUT.
  - Exactly NUM_REGS MAC cycles.
- OUT:
  - One edge: r = acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0), then arithmetic shift right by OUT_SHIFT (round half toward +inf).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register the result into y; y_valid=1 for that one cycle; go to IDLE.
- Latency:
  - start sampled at edge E0 -> y/y_valid visible after edge E0+NUM_REGS+1.
  - Result available NUM_REGS+2 cycles after start is presented.
  - Throughput: one sample per NUM_REGS+2 cycles; start may be re-asserted in the cycle y_valid is high (state is IDLE).
- start while busy=1: ignored, set overrun=1 (cleared only by rst); the computation in progress is unaffected.
- Coefficient writes:
  - coef_we=1 while IDLE and not starting a computation: coef[coef_addr] <= coef_data at the edge.
  - coef_we while busy, or in the same cycle as an accepted start: the write is dropped silently.
  - An out-of-range addr (NUM_REGS not a power of 2) is dropped.
- y holds its value between results; y_valid low otherwise.

Test Plan:
- Reset, then start with taps {1,2,3,4} (NUM_REGS=4) -> y_valid pulses 6 cycles after start, y=0; busy high exactly 5 cycles; overrun=0.
- Write coefs {1,1,1,1}, taps {1,2,3,4}, OUT_SHIFT=0 -> y=10. Then coefs {-2,3,0,1}, taps {5,-4,7,-1} -> y=-23.
- Saturation, DATA_WIDTH=16, NUM_REGS=4: coefs all 32767, taps all 32767 -> y=32767. Taps all -32768 -> y=-32768.
- Rounding with OUT_SHIFT=2, coefs {1,0,0,0}: tap0=10 -> y=3; tap0=-10 -> y=-2; tap0=6 -> y=2.
- Assert start again 2 cycles after an accepted start -> ignored, overrun=1, first result correct. Coef write during busy -> coef unchanged (verified by next result).
- Assert rst during MAC cycle 2 -> no y_valid, y=0, coefs=0. Rewrite coefs {1,1,1,1}, start with {1,2,3,4} -> y=10 with normal latency.
